// File: rtl/adq_pkg.sv
// Shared types and defaults for the acquisition scan sequencer.
package adq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SOC, S_WAIT, S_WRITE, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam int N_CH_DEF    = 4;
  localparam int DATA_W_DEF  = 12;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  // Mux select width; a single-bit select is kept even for degenerate sizes.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adq_scan_ctrl_if.sv
// ADC/mux/buffer datapath port: the sequencer is master, the datapath is slave.
interface adq_scan_ctrl_if #(
  parameter int N_CH   = adq_pkg::N_CH_DEF,
  parameter int DATA_W = adq_pkg::DATA_W_DEF
);
  localparam int CHW = adq_pkg::ch_w(N_CH);

  logic [CHW-1:0]        ch_sel;
  logic                  soc;
  logic                  eoc;
  logic [DATA_W-1:0]     adc_data;
  logic                  wr_en;
  logic                  wr_ready;
  logic [CHW+DATA_W-1:0] wr_data;

  modport master (output ch_sel, soc, wr_en, wr_data, input eoc, adc_data, wr_ready);
  modport slave  (input ch_sel, soc, wr_en, wr_data, output eoc, adc_data, wr_ready);
endinterface

// File: rtl/adq_ch_pick.sv
// Finds the lowest enabled channel (first mode) or the lowest enabled channel above cur (next mode).
module adq_ch_pick import adq_pkg::*; #(
  parameter int  N_CH = N_CH_DEF,
  localparam int CHW  = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CHW-1:0]  cur,
  input  logic            mode_next,
  output logic [CHW-1:0]  ch,
  output logic            found
);
  // Descending scan so the last hit written is the lowest qualifying index.
  always_comb begin
    ch    = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (!mode_next || i > int'(cur))) begin
        ch    = CHW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adq_scan_ctrl.sv
// Multi-channel scan sequencer: steps the mux over enabled channels, converts each,
// and pushes {channel, result} to the sample buffer for n_scans full scans.
module adq_scan_ctrl import adq_pkg::*; #(
  parameter int N_CH    = N_CH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 abort,
  input  logic [N_CH-1:0]      ch_mask,
  input  logic [CNT_W-1:0]     n_scans,
  adq_scan_ctrl_if.master      dp,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     scan_cnt
);
  localparam int CHW = ch_w(N_CH);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic [N_CH-1:0]       mask_q;
  logic [CNT_W-1:0]      nsc_q;
  logic [CNT_W-1:0]      scan_nxt;
  logic [TW-1:0]         tmr;
  logic [CHW-1:0]        ch_sel_q;
  logic [CHW+DATA_W-1:0] wr_data_q;
  logic                  idle_st;

  // Picker 0: lowest enabled (live mask while idle, latched mask otherwise).
  // Picker 1: next enabled above the current channel.
  logic [1:0][N_CH-1:0]  pk_mask;
  logic [1:0][CHW-1:0]   pk_ch;
  logic [1:0]            pk_found;

  assign idle_st    = state inside {S_IDLE, S_DONE, S_ERR};
  assign pk_mask[0] = idle_st ? ch_mask : mask_q;
  assign pk_mask[1] = mask_q;
  assign scan_nxt   = scan_cnt + 1'b1;

  for (genvar g = 0; g < 2; g++) begin : g_pick
    adq_ch_pick #(.N_CH(N_CH)) u_pick (
      .mask      (pk_mask[g]),
      .cur       (ch_sel_q),
      .mode_next (1'(g)),
      .ch        (pk_ch[g]),
      .found     (pk_found[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (init) state_nxt = (ch_mask == '0 || n_scans == '0) ? S_DONE : S_SEL;
      S_SEL:   state_nxt = S_SOC;
      S_SOC:   state_nxt = S_WAIT;
      S_WAIT:
        if (dp.eoc)                        state_nxt = S_WRITE;
        else if (tmr == TW'(TIMEOUT - 1)) state_nxt = S_ERR;
      S_WRITE: if (dp.wr_ready) state_nxt = S_NEXT;
      S_NEXT:
        if (pk_found[1])            state_nxt = S_SEL;
        else if (scan_nxt == nsc_q) state_nxt = S_DONE;
        else                        state_nxt = S_SEL;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q    <= '0;
      nsc_q     <= '0;
      scan_cnt  <= '0;
      tmr       <= '0;
      ch_sel_q  <= '0;
      wr_data_q <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE, S_DONE, S_ERR:
          if (init) begin
            mask_q   <= ch_mask;
            nsc_q    <= n_scans;
            scan_cnt <= '0;
            if (pk_found[0]) ch_sel_q <= pk_ch[0];
          end
        S_SOC: tmr <= '0;
        S_WAIT:
          if (dp.eoc) wr_data_q <= {ch_sel_q, dp.adc_data};
          else        tmr       <= tmr + 1'b1;
        S_NEXT:
          if (pk_found[1]) ch_sel_q <= pk_ch[1];
          else begin
            scan_cnt <= scan_nxt;
            if (scan_nxt != nsc_q) ch_sel_q <= pk_ch[0];
          end
        default: ;
      endcase
    end
  end

  assign dp.ch_sel   = ch_sel_q;
  assign dp.soc      = (state == S_SOC);
  assign dp.wr_en    = (state == S_WRITE);
  assign dp.wr_data  = wr_data_q;
  assign busy        = !idle_st;
  assign done        = (state == S_DONE);
  assign err_timeout = (state == S_ERR);
endmodule

// File: tb/tb_adq_scan_ctrl.sv
// Directed bench for adq_scan_ctrl with a small ADC responder and write monitor.
module tb_adq_scan_ctrl;
  logic       clk = 1'b0, rst = 1'b0, init = 1'b0, abort = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [7:0] n_scans = '0;
  logic       busy, done, err_timeout;
  logic [7:0] scan_cnt;

  adq_scan_ctrl_if #(.N_CH(4), .DATA_W(12)) dp();

  adq_scan_ctrl #(.N_CH(4), .DATA_W(12), .CNT_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .init(init), .abort(abort), .ch_mask(ch_mask),
    .n_scans(n_scans), .dp(dp), .busy(busy), .done(done),
    .err_timeout(err_timeout), .scan_cnt(scan_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [13:0] wq[$];
  int          soc_n = 0;
  bit          adc_en = 1'b0;
  int          eoc_dly = 3;
  int          adc_k = 0;

  always @(negedge clk) begin
    if (dp.wr_en && dp.wr_ready) wq.push_back(dp.wr_data);
    if (dp.soc) soc_n++;
  end

  // ADC model: one-cycle eoc eoc_dly cycles after each soc, data 0x100 + index
  initial begin
    dp.eoc = 1'b0;
    dp.adc_data = '0;
    forever begin
      @(posedge clk); #1;
      if (adc_en && dp.soc) begin
        repeat (eoc_dly) @(posedge clk);
        #1;
        dp.eoc = 1'b1;
        dp.adc_data = 12'h100 + 12'(adc_k);
        adc_k++;
        @(posedge clk); #1;
        dp.eoc = 1'b0;
      end
    end
  end

  task automatic do_init(input logic [3:0] m, input logic [7:0] n);
    ch_mask = m; n_scans = n; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    n_chk++; if (dp.soc !== 1'b0) begin n_fail++; $display("FAIL reset_soc: got %b want 0", dp.soc); end
    n_chk++; if (dp.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", dp.wr_en); end
    n_chk++; if (dp.ch_sel !== 2'd0) begin n_fail++; $display("FAIL reset_ch_sel: got %0d want 0", dp.ch_sel); end
    n_chk++; if (dp.wr_data !== 14'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", dp.wr_data); end
    n_chk++; if (scan_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_scan_cnt: got %0d want 0", scan_cnt); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [1:0]  exp_ch[6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [13:0] exp_w;
    wq.delete(); soc_n = 0; adc_k = 0; adc_en = 1'b1; eoc_dly = 3; dp.wr_ready = 1'b1;
    do_init(4'b1011, 8'd2);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_sel: got %b want 1", busy); end
    n_chk++; if (dp.soc !== 1'b0) begin n_fail++; $display("FAIL basic_soc_k1: got %b want 0", dp.soc); end
    @(posedge clk); #1;
    n_chk++; if (dp.soc !== 1'b1) begin n_fail++; $display("FAIL basic_soc_k2: got %b want 1", dp.soc); end
    // init while busy must not disturb the run
    ch_mask = 4'b1111; n_scans = 8'd5; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin @(posedge clk); #1; end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    n_chk++; if (scan_cnt !== 8'd2) begin n_fail++; $display("FAIL basic_scan_cnt: got %0d want 2", scan_cnt); end
    n_chk++; if (wq.size() != 6) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 6", wq.size()); end
    n_chk++; if (soc_n != 6) begin n_fail++; $display("FAIL basic_nsoc: got %0d want 6", soc_n); end
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      exp_w = {exp_ch[i], 12'(12'h100 + i)};
      n_chk++;
      if (wq[i] !== exp_w) begin n_fail++; $display("FAIL basic_write%0d: got %h want %h", i, wq[i], exp_w); end
    end
  endtask

  task automatic test_empty;
    wq.delete(); soc_n = 0; adc_en = 1'b1;
    do_init(4'b0000, 8'd3);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b want 0", busy); end
    n_chk++; if (scan_cnt !== 8'd0) begin n_fail++; $display("FAIL empty_scan_cnt: got %0d want 0", scan_cnt); end
    repeat (5) begin @(posedge clk); #1; end
    n_chk++; if (soc_n != 0) begin n_fail++; $display("FAIL empty_nsoc: got %0d want 0", soc_n); end
    n_chk++; if (wq.size() != 0) begin n_fail++; $display("FAIL empty_nwrites: got %0d want 0", wq.size()); end
    do_init(4'b0101, 8'd0);
    repeat (3) begin @(posedge clk); #1; end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL zscan_done: got %b want 1", done); end
    n_chk++; if (soc_n != 0) begin n_fail++; $display("FAIL zscan_nsoc: got %0d want 0", soc_n); end
  endtask

  task automatic test_timeout;
    int cyc;
    adc_en = 1'b0;
    do_init(4'b0001, 8'd1);
    @(posedge clk); #1;
    n_chk++; if (dp.soc !== 1'b1) begin n_fail++; $display("FAIL to_soc: got %b want 1", dp.soc); end
    cyc = 0;
    for (int i = 0; i < 400 && !err_timeout; i++) begin @(posedge clk); #1; cyc++; end
    n_chk++; if (cyc != 256) begin n_fail++; $display("FAIL to_latency: got %0d want 256", cyc); end
    n_chk++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err_timeout); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
    do_init(4'b0000, 8'd1);
    n_chk++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", err_timeout); end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL to_reinit_done: got %b want 1", done); end
  endtask

  task automatic test_backpressure;
    logic [13:0] exp_w;
    exp_w = {2'd2, 12'h100};
    wq.delete(); adc_k = 0; adc_en = 1'b1; eoc_dly = 1; dp.wr_ready = 1'b0;
    do_init(4'b0100, 8'd1);
    for (int i = 0; i < 50 && !dp.wr_en; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (dp.wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_wr_en%0d: got %b want 1", i, dp.wr_en); end
      n_chk++; if (dp.wr_data !== exp_w) begin n_fail++; $display("FAIL bp_wr_data%0d: got %h want %h", i, dp.wr_data, exp_w); end
      @(posedge clk); #1;
    end
    dp.wr_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin @(posedge clk); #1; end
    n_chk++; if (wq.size() != 1) begin n_fail++; $display("FAIL bp_nwrites: got %0d want 1", wq.size()); end
    if (wq.size() > 0) begin
      n_chk++; if (wq[0] !== exp_w) begin n_fail++; $display("FAIL bp_word: got %h want %h", wq[0], exp_w); end
    end
    n_chk++; if (scan_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_scan_cnt: got %0d want 1", scan_cnt); end
  endtask

  task automatic test_abort;
    wq.delete(); soc_n = 0; adc_k = 0; adc_en = 1'b1; eoc_dly = 3; dp.wr_ready = 1'b1;
    do_init(4'b1011, 8'd2);
    // abort in WAIT of the first channel of the second scan
    for (int i = 0; i < 100 && soc_n < 4; i++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b want 0", busy); end
    n_chk++; if (dp.soc !== 1'b0) begin n_fail++; $display("FAIL ab_soc: got %b want 0", dp.soc); end
    n_chk++; if (dp.wr_en !== 1'b0) begin n_fail++; $display("FAIL ab_wr_en: got %b want 0", dp.wr_en); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL ab_done: got %b want 0", done); end
    n_chk++; if (scan_cnt !== 8'd1) begin n_fail++; $display("FAIL ab_scan_cnt: got %0d want 1", scan_cnt); end
    repeat (6) begin @(posedge clk); #1; end
    n_chk++; if (wq.size() != 3) begin n_fail++; $display("FAIL ab_nwrites: got %0d want 3", wq.size()); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_stay_idle: got %b want 0", busy); end
    wq.delete(); adc_k = 0;
    do_init(4'b1011, 8'd1);
    n_chk++; if (dp.ch_sel !== 2'd0) begin n_fail++; $display("FAIL ab_restart_ch: got %0d want 0", dp.ch_sel); end
    for (int i = 0; i < 100 && !done; i++) begin @(posedge clk); #1; end
    n_chk++; if (wq.size() != 3) begin n_fail++; $display("FAIL ab_restart_nwrites: got %0d want 3", wq.size()); end
    if (wq.size() > 0) begin
      n_chk++; if (wq[0] !== {2'd0, 12'h100}) begin n_fail++; $display("FAIL ab_restart_word: got %h want %h", wq[0], {2'd0, 12'h100}); end
    end
  endtask

  task automatic test_rst_mid;
    wq.delete(); adc_k = 0; adc_en = 1'b1; eoc_dly = 1; dp.wr_ready = 1'b0;
    do_init(4'b0100, 8'd1);
    for (int i = 0; i < 50 && !dp.wr_en; i++) begin @(posedge clk); #1; end
    n_chk++; if (dp.wr_en !== 1'b1) begin n_fail++; $display("FAIL rm_in_write: got %b want 1", dp.wr_en); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (dp.wr_en !== 1'b0) begin n_fail++; $display("FAIL rm_wr_en: got %b want 0", dp.wr_en); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_chk++; if (dp.wr_data !== 14'd0) begin n_fail++; $display("FAIL rm_wr_data: got %h want 0", dp.wr_data); end
    n_chk++; if (dp.ch_sel !== 2'd0) begin n_fail++; $display("FAIL rm_ch_sel: got %0d want 0", dp.ch_sel); end
    n_chk++; if (scan_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_scan_cnt: got %0d want 0", scan_cnt); end
    dp.wr_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_post_busy: got %b want 0", busy); end
    n_chk++; if (wq.size() != 0) begin n_fail++; $display("FAIL rm_nwrites: got %0d want 0", wq.size()); end
  endtask

  initial begin
    dp.wr_ready = 1'b1;
    test_reset();
    test_basic();
    test_empty();
    test_timeout();
    test_backpressure();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adq_scan_ctrl.md
# adq_scan_ctrl

Multi-channel scan sequencer for the acquisition datapath. On `init` it steps an analog mux over the enabled channels, issues one start-of-conversion pulse per channel, waits for `eoc` (with timeout), captures the converter result and hands it to the sample buffer over a valid/ready write port. It repeats full scans until the programmed scan count is reached, then reports `done`. It sits between the host control registers and the ADC/mux/buffer datapath.

## Interface
- `N_CH`, 4: number of mux channels (≥2)
- `DATA_W`, 12: ADC result width
- `CNT_W`, 8: scan-count width
- `TIMEOUT`, 255: maximum cycles spent in WAIT before error
- `clk` in 1: system clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `init` in 1: start request, sampled only in IDLE/DONE/ERR
- `abort` in 1: synchronous stop, highest priority after reset
- `ch_mask` in N_CH: enabled channels, latched at accepted `init`
- `n_scans` in CNT_W: number of full scans, latched at accepted `init`
- `eoc` in 1: end of conversion from ADC
- `adc_data` in DATA_W: ADC result, valid while `eoc`=1
- `wr_ready` in 1: buffer can accept a word
- `ch_sel` out CHW=$clog2(N_CH): mux select
- `soc` out 1: start-of-conversion pulse
- `wr_en` out 1: write valid
- `wr_data` out CHW+DATA_W: {channel, result}
- `busy` out 1: state not IDLE/DONE/ERR
- `done` out 1: run complete (level)
- `err_timeout` out 1: WAIT timed out (level)
- `scan_cnt` out CNT_W: completed full scans

## Operation
- States: IDLE, SEL, SOC, WAIT, WRITE, NEXT, DONE, ERR.
- IDLE/DONE/ERR + `init`: latch `ch_mask`, `n_scans`; clear `scan_cnt`, `done`, `err_timeout`. If latched mask = 0 or `n_scans` = 0 → DONE; else `ch_sel` ← lowest enabled channel, → SEL.
- SEL: one mux settle cycle → SOC.
- SOC: `soc`=1 for exactly this cycle; clear timeout counter → WAIT.
- WAIT: `eoc`=1 → capture {ch_sel, adc_data} into `wr_data`, → WRITE. Else increment timer; timer reaching TIMEOUT → ERR (`err_timeout`=1).
- WRITE: `wr_en`=1, `wr_data` stable until `wr_ready` sampled 1 → NEXT.
- NEXT: next enabled channel above `ch_sel`. If found → SEL with it. If none (wrap): `scan_cnt`+1; if new value = `n_scans` → DONE, else `ch_sel` ← lowest enabled → SEL.
- DONE: `done`=1, hold until accepted `init`. ERR: hold until `init`.
- `init` while busy: ignored. `eoc` outside WAIT: ignored.
- `abort` in any state: → IDLE next edge, `wr_en`/`soc` drop, `scan_cnt` kept, `done`/`err_timeout` cleared.
- Reset values: state IDLE, all outputs 0, `ch_sel`=0, `wr_data`=0.
- `scan_cnt` never wraps: terminal compare stops at `n_scans` ≤ 2^CNT_W−1.

## Timing
- `init` accepted at edge k → SEL at k+1, `soc`=1 in cycle k+2.
- Minimum per conversion (eoc in first WAIT cycle, wr_ready=1): SEL, SOC, WAIT, WRITE, NEXT = 5 cycles.
- `wr_en` rises the cycle after `eoc` sampled; backpressure stalls indefinitely (no timeout in WRITE).
- `done` rises the cycle after last NEXT; `busy` falls same cycle.
- Timeout: `err_timeout` rises TIMEOUT+1 cycles after `soc`.
- All outputs registered or decoded from registered state; no combinational path input→output.

## Structure
- `adq_pkg`: state enum, default parameter constants, CHW function.
- Sub-module `adq_ch_pick`: combinational next-enabled-channel finder (mask, current, mode first/next → channel, found); used for init and NEXT.

## Test plan
- N_CH=4, mask=4'b1011, n_scans=2, eoc 3 cycles after each soc, wr_ready=1 → 6 writes, channels 0,1,3,0,1,3; scan_cnt=2; done=1.
- mask=4'b0000, init → DONE next cycle, zero `soc`, zero `wr_en`, scan_cnt=0.
- mask=4'b0001, eoc never asserted → err_timeout=1 exactly 256 cycles after soc, busy=0; new init clears it.
- wr_ready held 0 for 10 cycles in WRITE → wr_en and wr_data stable all 10 cycles, exactly one write accepted.
- abort asserted during WAIT of scan 1 → IDLE next edge, soc/wr_en 0, done=0; later init restarts from lowest channel.
- rst low mid-WRITE → all outputs 0 immediately, no clock required; init while busy ignored (ch_sel sequence unchanged).
